// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipeline_controller_pkg;

   typedef enum logic [1:0] {
      CTL_RUN         = 2'd0,
      CTL_REDIRECT    = 2'd1,
      CTL_ALU_WAIT    = 2'd2,
      CTL_LOAD_BUBBLE = 2'd3
   } ctl_state_e;

endpackage

// File: rtl/pipeline_controller_load_use_detect.sv
// Load-use hazard comparator: a load in execute whose rd feeds the decode stage.
module load_use_detect #(
   parameter int unsigned AWIDTH = 5
) (
   input  logic [AWIDTH-1:0] id_addr_rs1_i,
   input  logic [AWIDTH-1:0] id_addr_rs2_i,
   input  logic [AWIDTH-1:0] ex_addr_rd_i,
   input  logic              ex_is_load_i,
   input  logic              ex_valid_i,
   output logic              hazard_o
);

   always_comb begin
      hazard_o = ex_valid_i && ex_is_load_i && (ex_addr_rd_i != '0) &&
                 ((ex_addr_rd_i == id_addr_rs1_i) || (ex_addr_rd_i == id_addr_rs2_i));
   end

endmodule

// File: rtl/pipeline_controller.sv
// Central stall/flush sequencer: registered FSM, combinational control outputs
// so a hazard is acted on in the same cycle it appears.
module pipeline_controller
   import pipeline_controller_pkg::*;
#(
   parameter int unsigned AWIDTH       = 5,
   parameter int unsigned PC_WIDTH     = 32,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                 ctl_clk,
   input  logic                 ctl_rst,
   input  logic [AWIDTH-1:0]    ctl_i_id_addr_rs1,
   input  logic [AWIDTH-1:0]    ctl_i_id_addr_rs2,
   input  logic [AWIDTH-1:0]    ctl_i_ex_addr_rd,
   input  logic                 ctl_i_ex_is_load,
   input  logic                 ctl_i_ex_valid,
   input  logic                 ctl_i_ex_change_pc,
   input  logic [PC_WIDTH-1:0]  ctl_i_ex_next_pc,
   input  logic                 ctl_i_alu_busy,
   input  logic                 ctl_i_mem_stall,
   output logic                 ctl_o_stall_if,
   output logic                 ctl_o_stall_id,
   output logic                 ctl_o_stall_ex,
   output logic                 ctl_o_flush_id,
   output logic                 ctl_o_flush_ex,
   output logic                 ctl_o_pc_load,
   output logic [PC_WIDTH-1:0]  ctl_o_pc_target,
   output logic [1:0]           ctl_o_state,
   output logic [CNT_WIDTH-1:0] ctl_o_stall_cycles
);

   localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   ctl_state_e           state_q, state_d;
   logic [FCW-1:0]       fcnt_q, fcnt_d;
   logic [CNT_WIDTH-1:0] scnt_q, scnt_d;
   logic                 hazard;

   load_use_detect #(.AWIDTH(AWIDTH)) u_load_use_detect (
      .id_addr_rs1_i (ctl_i_id_addr_rs1),
      .id_addr_rs2_i (ctl_i_id_addr_rs2),
      .ex_addr_rd_i  (ctl_i_ex_addr_rd),
      .ex_is_load_i  (ctl_i_ex_is_load),
      .ex_valid_i    (ctl_i_ex_valid),
      .hazard_o      (hazard)
   );

   always_ff @(posedge ctl_clk or posedge ctl_rst) begin
      if (ctl_rst) begin
         state_q <= CTL_RUN;
         fcnt_q  <= '0;
         scnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         scnt_q  <= scnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         CTL_RUN: begin
            if (ctl_i_mem_stall) begin
               state_d = CTL_RUN;
            end else if (ctl_i_ex_change_pc) begin
               fcnt_d  = FCW'(FLUSH_CYCLES - 1);
               state_d = (fcnt_d != '0) ? CTL_REDIRECT : CTL_RUN;
            end else if (ctl_i_alu_busy) begin
               state_d = CTL_ALU_WAIT;
            end else if (hazard) begin
               state_d = CTL_LOAD_BUBBLE;
            end
         end
         // The RUN cycle that raised the redirect is the first flush cycle,
         // so leave REDIRECT on the edge where the counter hits zero.
         CTL_REDIRECT: begin
            if (!ctl_i_mem_stall) begin
               if (fcnt_q <= FCW'(1)) begin
                  fcnt_d  = '0;
                  state_d = CTL_RUN;
               end else begin
                  fcnt_d = fcnt_q - 1'b1;
               end
            end
         end
         CTL_ALU_WAIT: begin
            if (!(ctl_i_alu_busy || ctl_i_mem_stall)) state_d = CTL_RUN;
         end
         CTL_LOAD_BUBBLE: begin
            if (!ctl_i_mem_stall) state_d = CTL_RUN;
         end
         default: state_d = CTL_RUN;
      endcase
   end

   always_comb begin
      ctl_o_stall_if  = 1'b0;
      ctl_o_stall_id  = 1'b0;
      ctl_o_stall_ex  = 1'b0;
      ctl_o_flush_id  = 1'b0;
      ctl_o_flush_ex  = 1'b0;
      ctl_o_pc_load   = 1'b0;
      case (state_q)
         CTL_RUN: begin
            if (ctl_i_mem_stall || (!ctl_i_ex_change_pc && ctl_i_alu_busy)) begin
               ctl_o_stall_if = 1'b1;
               ctl_o_stall_id = 1'b1;
               ctl_o_stall_ex = 1'b1;
            end else if (ctl_i_ex_change_pc) begin
               ctl_o_pc_load  = 1'b1;
               ctl_o_flush_id = 1'b1;
               ctl_o_flush_ex = 1'b1;
            end else if (hazard) begin
               ctl_o_stall_if = 1'b1;
               ctl_o_stall_id = 1'b1;
               ctl_o_flush_ex = 1'b1;
            end
         end
         CTL_REDIRECT: begin
            ctl_o_flush_id = 1'b1;
            ctl_o_flush_ex = 1'b1;
            ctl_o_stall_if = ctl_i_mem_stall;
         end
         CTL_ALU_WAIT, CTL_LOAD_BUBBLE: begin
            if (ctl_i_mem_stall || (state_q == CTL_ALU_WAIT && ctl_i_alu_busy)) begin
               ctl_o_stall_if = 1'b1;
               ctl_o_stall_id = 1'b1;
               ctl_o_stall_ex = 1'b1;
            end
         end
         default: ;
      endcase
      if (ctl_rst) begin
         ctl_o_stall_if = 1'b0;
         ctl_o_stall_id = 1'b0;
         ctl_o_stall_ex = 1'b0;
         ctl_o_flush_id = 1'b0;
         ctl_o_flush_ex = 1'b0;
         ctl_o_pc_load  = 1'b0;
      end
      ctl_o_pc_target = ctl_o_pc_load ? ctl_i_ex_next_pc : '0;
   end

   always_comb begin
      scnt_d = scnt_q;
      if (ctl_o_stall_if && (scnt_q != '1)) scnt_d = scnt_q + 1'b1;
   end

   assign ctl_o_state        = state_q;
   assign ctl_o_stall_cycles = scnt_q;

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the five-stage RV32 pipeline, and the control counterpart of `execute_stage`. It watches the execute stage and the stages around it for redirect, multi-cycle ALU, load-use and memory-wait events. From these it drives:
- per-stage stall and flush lines;
- the fetch PC redirect;
- a stall-cycle performance counter.

All sequencing decisions are held in a registered FSM. Control outputs are combinational from the state and the current inputs, so a hazard is acted on in the same cycle it appears.

## Interface
Parameters:
- AWIDTH, 5, register address width
- PC_WIDTH, 32, program counter width
- FLUSH_CYCLES, 2, number of cycles ID/EX are flushed after a redirect (≥1)
- CNT_WIDTH, 16, stall counter width

Ports:
- ctl_clk  in  1  clock, rising edge
- ctl_rst  in  1  reset; asynchronous, active-high
- ctl_i_id_addr_rs1  in  AWIDTH  rs1 of instruction in decode
- ctl_i_id_addr_rs2  in  AWIDTH  rs2 of instruction in decode
- ctl_i_ex_addr_rd  in  AWIDTH  rd of instruction in execute
- ctl_i_ex_is_load  in  1  execute holds a load
- ctl_i_ex_valid  in  1  execute holds a valid instruction
- ctl_i_ex_change_pc  in  1  execute resolved a taken branch/jump
- ctl_i_ex_next_pc  in  PC_WIDTH  redirect target from execute
- ctl_i_alu_busy  in  1  multi-cycle ALU op in progress (execute's stall_from_alu)
- ctl_i_mem_stall  in  1  data memory not ready
- ctl_o_stall_if / ctl_o_stall_id / ctl_o_stall_ex  out  1 each  hold the stage register
- ctl_o_flush_id / ctl_o_flush_ex  out  1 each  invalidate the stage register
- ctl_o_pc_load  out  1  one-cycle pulse: fetch loads ctl_o_pc_target
- ctl_o_pc_target  out  PC_WIDTH  equals ctl_i_ex_next_pc when pc_load=1, else 0
- ctl_o_state  out  2  current FSM state
- ctl_o_stall_cycles  out  CNT_WIDTH  count of cycles with ctl_o_stall_if=1, saturating

## Operation
- **States:** RUN=0, REDIRECT=1, ALU_WAIT=2, LOAD_BUBBLE=3.
- **Load-use hazard:**
  - Condition: ex_valid & ex_is_load & ex_addr_rd≠0 & (ex_addr_rd==id_rs1 | ex_addr_rd==id_rs2).
- **RUN**, evaluated in priority order:
  1. mem_stall: assert stall_if/id/ex; stay in RUN.
  2. change_pc: assert pc_load=1, pc_target=ex_next_pc, flush_id=flush_ex=1.
     - Load the flush counter with FLUSH_CYCLES-1.
     - Go to REDIRECT if the counter is non-zero, else RUN.
  3. alu_busy: assert stall_if/id/ex; go to ALU_WAIT.
  4. load-use: assert stall_if/id and flush_ex (bubble); go to LOAD_BUBBLE.
  5. Otherwise all control outputs are 0.
- **REDIRECT:**
  - Assert flush_id=flush_ex=1 every cycle.
  - Decrement the counter each cycle; return to RUN in the cycle after the counter reaches 0.
  - mem_stall: additionally assert stall_if, and freeze the counter.
  - change_pc is ignored, because the flushed stages hold no valid instruction.
- **ALU_WAIT:**
  - While alu_busy|mem_stall, assert stall_if/id/ex.
  - When both are low, return to RUN with no stall asserted that cycle.
  - change_pc during ALU_WAIT is ignored. Execute does not raise it while busy.
- **LOAD_BUBBLE:**
  - Lasts one cycle and asserts no stall or flush; it blocks re-detection of the same hazard.
  - Next state: RUN, unless mem_stall, which asserts stall_if/id/ex and holds LOAD_BUBBLE.
- **Stall counter:** increments when stall_if=1 and holds at all-ones.
- **Reset:**
  - While ctl_rst=1, every control output is forced to 0, regardless of inputs.
  - State=RUN, flush counter=0, ctl_o_stall_cycles=0.

## Timing
- State, flush counter and stall counter update on the rising edge of ctl_clk. They clear asynchronously on ctl_rst rising.
- Control outputs have zero latency, combinational from state and inputs. Redirect latency is therefore 0 cycles: fetch loads the target on the same edge that ends the redirect cycle.
- Total flush length after a redirect = FLUSH_CYCLES cycles, plus any mem_stall cycles inside REDIRECT.
- Reset asserted mid-REDIRECT or mid-ALU_WAIT returns the FSM to RUN immediately. There is no pending redirect after reset is released.
- Simultaneous change_pc and load-use in RUN: redirect wins, and no bubble is inserted.

## Structure
- State encodings (`CTL_RUN`, `CTL_REDIRECT`, `CTL_ALU_WAIT`, `CTL_LOAD_BUBBLE`) go in the shared header alongside the ALU/opcode defines.
- One sub-module: `load_use_detect`, the combinational comparator producing the hazard bit.
- Everything else lives in pipeline_controller.

## Test plan
- **Reset:** reset with every input high → all outputs 0, ctl_o_state=0.
  - After release, with inputs quiet, the state holds at 0 and the counter at 0.
- **Load-use:** ex_is_load=1, ex_valid=1, ex_rd=5, id_rs2=5 → same cycle: stall_if=stall_id=flush_ex=1.
  - Next cycle: state=3, all outputs 0. Following cycle: state=0.
  - A repeat with ex_rd=0 → no stall.
- **Redirect:** change_pc=1, next_pc=0x4000 → pc_load=1, pc_target=0x4000, flush_id=flush_ex=1.
  - Next cycle: state=1, flushes still 1. Then RUN.
- **ALU wait:** alu_busy=1 for 4 cycles → stall_if/id/ex=1 for 4 cycles, state=2.
  - The cycle after alu_busy drops: no stall; ctl_o_stall_cycles=4.
- **Collisions:**
  - change_pc and load-use together → redirect only, no bubble.
  - mem_stall during REDIRECT for 2 cycles → flush lasts FLUSH_CYCLES+2 cycles.
- **Async reset in ALU_WAIT:** assert ctl_rst between clock edges → stall lines drop immediately and state=0.
